// File: rtl/prog_loader_pkg.sv
// Shared operation encodings and FSM state codes for the program loader.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_LOAD   = 2'b01,
        OP_VERIFY = 2'b10,
        OP_CLEAR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WR      = 2'b01,
        ST_RD_WAIT = 2'b10,
        ST_RD_CHK  = 2'b11
    } state_e;

endpackage

// File: rtl/prog_loader_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, counting debouncer, press pulse.
// Reusable for any active-low raw button in the clock domain of clk_i.
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic level_o,
    output logic press_o
);
    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Synchronise, then change level only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_q <= sync2_q;
                press_q <= ~sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/prog_loader.sv
// Debounced push-button memory programmer: write+increment, load, verify, clear.
// Optional running checksum of written data: define PROG_LOADER_CHKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int DEB_CYCLES = 16
) (
    input  logic          clock_i,
    input  logic          reset_n_i,
    input  logic          mode_i,
    input  logic          p_button_i,
    input  logic [1:0]    op_i,
    input  logic [DW-1:0] data_in_i,
    input  logic [DW-1:0] mem_q_i,
    output logic [AW-1:0] prog_adrs_o,
    output logic [DW-1:0] prog_data_o,
    output logic          prog_wr_en_o,
    output logic          busy_o,
    output logic          verify_err_o,
    output logic          wrap_o,
    output logic [DW-1:0] chksum_o
);
    state_e        state_q;
    logic [AW-1:0] adrs_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] cmp_q;
    logic          wr_en_q;
    logic          busy_q;
    logic          err_q;
    logic          wrap_q;
    logic          press_s;
    logic          level_s;
    logic [AW-1:0] adrs_inc_d;
    logic          adrs_carry_d;
    logic          accept_s;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk_i   (clock_i),
        .rst_ni  (reset_n_i),
        .btn_ni  (p_button_i),
        .level_o (level_s),
        .press_o (press_s)
    );

    assign {adrs_carry_d, adrs_inc_d} = {1'b0, adrs_q} + {{AW{1'b0}}, 1'b1};
    assign accept_s = press_s & mode_i & (state_q == ST_IDLE);

    // Operation sequencer; leaving program mode aborts any op without touching address/data
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            adrs_q  <= '0;
            data_q  <= '0;
            cmp_q   <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (!mode_i) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept_s) begin
                            case (op_i)
                                OP_WRITE: begin
                                    data_q  <= data_in_i;
                                    wr_en_q <= 1'b1;
                                    busy_q  <= 1'b1;
                                    state_q <= ST_WR;
                                end
                                OP_LOAD: adrs_q <= AW'(data_in_i);
                                OP_VERIFY: begin
                                    cmp_q   <= data_in_i;
                                    busy_q  <= 1'b1;
                                    state_q <= ST_RD_WAIT;
                                end
                                OP_CLEAR: begin
                                    adrs_q <= '0;
                                    err_q  <= 1'b0;
                                    wrap_q <= 1'b0;
                                end
                                default: state_q <= ST_IDLE;
                            endcase
                        end
                    end
                    ST_WR: begin
                        adrs_q  <= adrs_inc_d;
                        wrap_q  <= wrap_q | adrs_carry_d;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    ST_RD_WAIT: state_q <= ST_RD_CHK;
                    ST_RD_CHK: begin
                        data_q  <= mem_q_i;
                        err_q   <= err_q | (mem_q_i != cmp_q);
                        adrs_q  <= adrs_inc_d;
                        wrap_q  <= wrap_q | adrs_carry_d;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PROG_LOADER_CHKSUM_EN
    logic [DW-1:0] chksum_q;

    // Sum of every word actually written (WR cycle still in program mode)
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            chksum_q <= '0;
        end else if (accept_s && (op_i == OP_CLEAR)) begin
            chksum_q <= '0;
        end else if (mode_i && (state_q == ST_WR)) begin
            chksum_q <= chksum_q + data_q;
        end else begin
            chksum_q <= chksum_q;
        end
    end

    assign chksum_o = chksum_q;
`else
    assign chksum_o = '0;
`endif

    assign prog_adrs_o  = adrs_q;
    assign prog_data_o  = data_q;
    assign prog_wr_en_o = wr_en_q & mode_i;
    assign busy_o       = busy_q;
    assign verify_err_o = err_q;
    assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader with a RAM model and a write scoreboard.
module tb_prog_loader;
    logic       clk;
    logic       rst_n;
    logic       mode;
    logic       p_button;
    logic [1:0] op;
    logic [7:0] data_in;
    logic [7:0] mem_q;
    logic [7:0] prog_adrs;
    logic [7:0] prog_data;
    logic       prog_wr_en;
    logic       busy;
    logic       verify_err;
    logic       wrap;
    logic [7:0] chksum;

    logic [7:0]  mem [0:255];
    logic [15:0] sb_q [$];
    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    prog_loader dut (
        .clock_i     (clk),
        .reset_n_i   (rst_n),
        .mode_i      (mode),
        .p_button_i  (p_button),
        .op_i        (op),
        .data_in_i   (data_in),
        .mem_q_i     (mem_q),
        .prog_adrs_o (prog_adrs),
        .prog_data_o (prog_data),
        .prog_wr_en_o(prog_wr_en),
        .busy_o      (busy),
        .verify_err_o(verify_err),
        .wrap_o      (wrap),
        .chksum_o    (chksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with 1-cycle read latency
    always @(posedge clk) begin
        mem_q <= mem[prog_adrs];
        if (prog_wr_en) mem[prog_adrs] <= prog_data;
    end

    // Scoreboard: every write strobe must match the next expected {addr,data}
    always @(negedge clk) begin
        if (prog_wr_en === 1'b1) begin
            logic [15:0] exp;
            wr_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected got adrs=%h data=%h, no write expected", prog_adrs, prog_data);
            end else begin
                exp = sb_q.pop_front();
                if ({prog_adrs, prog_data} !== exp) begin
                    errors++;
                    $display("FAIL wr_data got %h/%h expected %h/%h", prog_adrs, prog_data, exp[15:8], exp[7:0]);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_press(input logic [1:0] o, input logic [7:0] d);
        op = o;
        data_in = d;
        p_button = 1'b0;
        cycles(30);
        p_button = 1'b1;
        cycles(30);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        sb_q.push_back({a, d});
    endtask

    task automatic wait_busy(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s busy never rose (got 0, required 1)", name);
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({prog_adrs, prog_data, prog_wr_en, busy, verify_err, wrap, chksum} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got adrs=%h data=%h we=%b busy=%b err=%b wrap=%b chk=%h required all 0",
                     prog_adrs, prog_data, prog_wr_en, busy, verify_err, wrap, chksum);
        end
    endtask

    task automatic test_write3;
        int wc0 = wr_count;
        for (int i = 0; i < 3; i++) begin
            push_wr(8'(i), 8'hA5);
            do_press(2'b00, 8'hA5);
        end
        checks++;
        if (prog_adrs !== 8'h03) begin errors++; $display("FAIL write3_adrs got %h required 03", prog_adrs); end
        checks++;
        if (wr_count - wc0 != 3) begin errors++; $display("FAIL write3_count got %0d required 3", wr_count - wc0); end
        checks++;
        if (mem[2] !== 8'hA5) begin errors++; $display("FAIL write3_mem2 got %h required a5", mem[2]); end
    endtask

    task automatic test_bounce;
        int wc0 = wr_count;
        op = 2'b00;
        data_in = 8'h5A;
        push_wr(8'h03, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            p_button = 1'b0; cycles(5);
            p_button = 1'b1; cycles(5);
        end
        p_button = 1'b0; cycles(30);
        p_button = 1'b1; cycles(30);
        checks++;
        if (wr_count - wc0 != 1) begin errors++; $display("FAIL bounce_count got %0d required 1", wr_count - wc0); end
        checks++;
        if (prog_adrs !== 8'h04) begin errors++; $display("FAIL bounce_adrs got %h required 04", prog_adrs); end
    endtask

    task automatic test_wrap;
        do_press(2'b01, 8'hFF);
        checks++;
        if (prog_adrs !== 8'hFF || busy !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_ff got adrs=%h busy=%b wrap=%b required ff/0/0", prog_adrs, busy, wrap);
        end
        push_wr(8'hFF, 8'h11);
        do_press(2'b00, 8'h11);
        checks++;
        if (prog_adrs !== 8'h00 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL wrap got adrs=%h wrap=%b required 00/1", prog_adrs, wrap);
        end
    endtask

    task automatic test_verify;
        do_press(2'b01, 8'h10);
        do_press(2'b10, 8'h3C);
        checks++;
        if (verify_err !== 1'b0 || prog_data !== 8'h3C || prog_adrs !== 8'h11) begin
            errors++;
            $display("FAIL verify_ok got err=%b data=%h adrs=%h required 0/3c/11", verify_err, prog_data, prog_adrs);
        end
        do_press(2'b10, 8'h00);
        checks++;
        if (verify_err !== 1'b1 || prog_data !== 8'h77 || prog_adrs !== 8'h12) begin
            errors++;
            $display("FAIL verify_bad got err=%b data=%h adrs=%h required 1/77/12", verify_err, prog_data, prog_adrs);
        end
        do_press(2'b01, 8'h20);
        checks++;
        if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_sticky got %b required 1", verify_err); end
    endtask

    task automatic test_mode;
        int wc0 = wr_count;
        bit ok;
        mode = 1'b0;
        do_press(2'b00, 8'h99);
        mode = 1'b1;
        cycles(2);
        checks++;
        if (wr_count != wc0 || prog_adrs !== 8'h20) begin
            errors++;
            $display("FAIL mode0_press got writes=%0d adrs=%h required 0/20", wr_count - wc0, prog_adrs);
        end
        // Abort a verify while it waits for read data
        op = 2'b10;
        data_in = 8'h55;
        p_button = 1'b0;
        wait_busy("abort", ok);
        mode = 1'b0;
        cycles(3);
        checks++;
        if (busy !== 1'b0 || prog_adrs !== 8'h20 || prog_data !== 8'h77 || verify_err !== 1'b1) begin
            errors++;
            $display("FAIL abort got busy=%b adrs=%h data=%h err=%b required 0/20/77/1", busy, prog_adrs, prog_data, verify_err);
        end
        p_button = 1'b1;
        cycles(30);
        mode = 1'b1;
        cycles(2);
        // Reset during RD_WAIT
        op = 2'b10;
        data_in = 8'h00;
        p_button = 1'b0;
        wait_busy("rst_rdwait", ok);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({prog_adrs, prog_data, prog_wr_en, busy, verify_err, wrap, chksum} !== 29'd0) begin
            errors++;
            $display("FAIL async_reset got adrs=%h data=%h busy=%b err=%b wrap=%b required all 0",
                     prog_adrs, prog_data, busy, verify_err, wrap);
        end
        p_button = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
    endtask

    task automatic test_chksum;
        logic [7:0] exp_sum;
`ifdef PROG_LOADER_CHKSUM_EN
        exp_sum = 8'h10;
`else
        exp_sum = 8'h00;
`endif
        push_wr(8'h00, 8'hF0);
        do_press(2'b00, 8'hF0);
        push_wr(8'h01, 8'h20);
        do_press(2'b00, 8'h20);
        checks++;
        if (chksum !== exp_sum) begin errors++; $display("FAIL chksum_sum got %h required %h", chksum, exp_sum); end
        do_press(2'b11, 8'h00);
        checks++;
        if (chksum !== 8'h00 || prog_adrs !== 8'h00 || verify_err !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL clear got chk=%h adrs=%h err=%b wrap=%b required 00/00/0/0", chksum, prog_adrs, verify_err, wrap);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h3C;
        mem[8'h11] = 8'h77;
        rst_n = 1'b0;
        mode = 1'b1;
        p_button = 1'b1;
        op = 2'b00;
        data_in = 8'h00;
        cycles(4);
        test_reset();
        rst_n = 1'b1;
        cycles(4);
        test_write3();
        test_bounce();
        test_wrap();
        test_verify();
        test_mode();
        test_chksum();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d pending writes required 0", sb_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
